// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: round-robin arbiter sharing one read port of the octree node memory between NUM_CORES cores
// Defining NODE_ARB_STATS_EN adds the stall_cycles and grant_count counters.
module node_mem_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_ren,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES-1:0]        busy
`ifdef NODE_ARB_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 grant_count
`endif
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [NUM_CORES-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, busy_q, busy_d;
  logic [NUM_CORES-1:0] elig, gsel, rsel;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic mem_ren_q, mem_ren_d, found;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IW-1:0] rr_q, rr_d, gid_q, gid_d, pick;
  logic [MEM_LATENCY-1:0] tv_q, tv_d;
  logic [MEM_LATENCY-1:0][IW-1:0] tid_q, tid_d;
  always_comb begin
    elig  = req & ~busy_q;
    found = 1'b0;
    pick  = rr_q;
    for (int o = 0; o < NUM_CORES; o++) begin
      if (!found && elig[(int'(rr_q) + o) % NUM_CORES]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + o) % NUM_CORES);
      end
    end
  end
  // The tag pipeline starts one cycle behind the grant, aligned with mem_ren.
  always_comb begin
    gsel       = found ? NUM_CORES'(1) << pick : '0;
    rsel       = tv_q[MEM_LATENCY-1] ? NUM_CORES'(1) << tid_q[MEM_LATENCY-1] : '0;
    gnt_d      = gsel;
    mem_ren_d  = found;
    mem_addr_d = found ? req_addr[int'(pick)*ADDR_W +: ADDR_W] : mem_addr_q;
    rr_d       = found ? IW'((int'(pick) + 1) % NUM_CORES) : rr_q;
    gid_d      = pick;
    busy_d     = (busy_q | gsel) & ~rsel;
    rvalid_d   = rsel;
    rdata_d    = tv_q[MEM_LATENCY-1] ? mem_rdata : rdata_q;
    tv_d       = tv_q;
    tid_d      = tid_q;
    tv_d[0]    = mem_ren_q;
    tid_d[0]   = gid_q;
    for (int s = 1; s < MEM_LATENCY; s++) begin
      tv_d[s]  = tv_q[s-1];
      tid_d[s] = tid_q[s-1];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= '0;
      rr_q       <= '0;
      gid_q      <= '0;
      tv_q       <= '0;
      tid_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      gid_q      <= gid_d;
      tv_q       <= tv_d;
      tid_q      <= tid_d;
    end
  end
  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_ren  = mem_ren_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
`ifdef NODE_ARB_STATS_EN
  logic [31:0] stall_q, stall_d, grant_q, grant_d;
  always_comb begin
    stall_d = (|(elig & (elig - NUM_CORES'(1)))) && stall_q != '1 ? stall_q + 32'd1 : stall_q;
    grant_d = mem_ren_q && grant_q != '1 ? grant_q + 32'd1 : grant_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      grant_q <= '0;
    end else begin
      stall_q <= stall_d;
      grant_q <= grant_d;
    end
  end
  assign stall_cycles = stall_q;
  assign grant_count  = grant_q;
`endif
endmodule

// File: tb/tb_node_mem_arbiter.sv
// tb_node_mem_arbiter: directed table-driven bench for node_mem_arbiter at MEM_LATENCY 1 and 3
module tb_node_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] req = '0, req3 = '0;
  logic [127:0] req_addr, req_addr3;
  logic [3:0] gnt, rvalid, busy, gnt3, rvalid3, busy3;
  logic [31:0] rdata, mem_addr, mem_rdata, rdata3, mem_addr3, mem_rdata3;
  logic mem_ren, mem_ren3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
`ifdef NODE_ARB_STATS_EN
  logic [31:0] stall_cycles, grant_count, stall_cycles3, grant_count3;
`endif
  node_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) d1 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
`ifdef NODE_ARB_STATS_EN
    , .stall_cycles(stall_cycles), .grant_count(grant_count)
`endif
  );
  node_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) d3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .req_addr(req_addr3), .gnt(gnt3), .rvalid(rvalid3),
    .rdata(rdata3), .mem_ren(mem_ren3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef NODE_ARB_STATS_EN
    , .stall_cycles(stall_cycles3), .grant_count(grant_count3)
`endif
  );
  localparam logic [31:0] A0 = 32'h100, A1 = 32'h200, A2 = 32'h40, A3 = 32'h300;
  assign req_addr  = {A3, A2, A1, A0};
  assign req_addr3 = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  function automatic logic [31:0] dfn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  logic [31:0] p1 = '0;
  logic [31:0] p3 [3] = '{default: '0};
  always @(posedge clk) begin
    p1    <= mem_ren ? dfn(mem_addr) : 32'hBAD0_BAD0;
    p3[0] <= mem_ren3 ? dfn(mem_addr3) : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata  = p1;
  assign mem_rdata3 = p3[2];
  logic [3:0] preq = '0;
  logic [127:0] paddr = '0;
  always @(negedge clk) begin
    if (reset_n)
      for (int i = 0; i < 4; i++)
        if (preq[i] && !gnt[i] && req[i] && req_addr[i*32 +: 32] != paddr[i*32 +: 32]) begin
          errors++;
          $display("FAIL addr_stable core %0d: addr %h while pending addr %h", i, req_addr[i*32 +: 32], paddr[i*32 +: 32]);
        end
    preq  <= req;
    paddr <= req_addr;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] maddr;
    logic [3:0]  busy;
    logic [3:0]  rv;
    logic [31:0] rd;
  } vec_t;
  vec_t tv [19];
  initial begin
    tv[0]  = '{4'hF, 4'h1, A0, 4'h1, 4'h0, 32'h0};
    tv[1]  = '{4'hF, 4'h2, A1, 4'h3, 4'h0, 32'h0};
    tv[2]  = '{4'hF, 4'h4, A2, 4'h6, 4'h1, dfn(A0)};
    tv[3]  = '{4'hF, 4'h8, A3, 4'hC, 4'h2, dfn(A1)};
    tv[4]  = '{4'hF, 4'h1, A0, 4'h9, 4'h4, dfn(A2)};
    tv[5]  = '{4'hF, 4'h2, A1, 4'h3, 4'h8, dfn(A3)};
    tv[6]  = '{4'h0, 4'h0, A1, 4'h2, 4'h1, dfn(A0)};
    tv[7]  = '{4'h0, 4'h0, A1, 4'h0, 4'h2, dfn(A1)};
    tv[8]  = '{4'h0, 4'h0, A1, 4'h0, 4'h0, dfn(A1)};
    tv[9]  = '{4'h4, 4'h4, A2, 4'h4, 4'h0, dfn(A1)};
    tv[10] = '{4'h0, 4'h0, A2, 4'h4, 4'h0, dfn(A1)};
    tv[11] = '{4'hA, 4'h8, A3, 4'h8, 4'h4, dfn(A2)};
    tv[12] = '{4'hA, 4'h2, A1, 4'hA, 4'h0, dfn(A2)};
    tv[13] = '{4'h0, 4'h0, A1, 4'h2, 4'h8, dfn(A3)};
    tv[14] = '{4'h0, 4'h0, A1, 4'h0, 4'h2, dfn(A1)};
    tv[15] = '{4'hF, 4'h4, A2, 4'h4, 4'h0, dfn(A1)};
    tv[16] = '{4'hF, 4'h8, A3, 4'hC, 4'h0, dfn(A1)};
    tv[17] = '{4'h0, 4'h0, A3, 4'h8, 4'h4, dfn(A2)};
    tv[18] = '{4'h0, 4'h0, A3, 4'h0, 4'h8, dfn(A3)};
    #12;
    chk("reset gnt", 32'(gnt), 0);
    chk("reset rvalid", 32'(rvalid), 0);
    chk("reset rdata", rdata, 0);
    chk("reset mem_ren", 32'(mem_ren), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset busy", 32'(busy), 0);
`ifdef NODE_ARB_STATS_EN
    chk("reset stall_cycles", stall_cycles, 0);
    chk("reset grant_count", grant_count, 0);
`endif
    reset_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step(tv[i].req);
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d mem_ren", i), 32'(mem_ren), 32'(|tv[i].gnt));
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].maddr);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tv[i].rv));
      chk($sformatf("vec%0d rdata", i), rdata, tv[i].rd);
    end
    // Latency 3: four back-to-back grants, responses exactly four cycles after each grant.
    req3 = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      step(4'h0);
      chk($sformatf("lat3 c%0d gnt", c), 32'(gnt3), (c <= 4) ? 32'(1) << (c - 1) : 0);
      chk($sformatf("lat3 c%0d mem_ren", c), 32'(mem_ren3), (c <= 4) ? 1 : 0);
      chk($sformatf("lat3 c%0d rvalid", c), 32'(rvalid3), (c >= 5 && c <= 8) ? 32'(1) << (c - 5) : 0);
      if (c >= 5 && c <= 8) chk($sformatf("lat3 c%0d rdata", c), rdata3, dfn(32'h1000 * (c - 4)));
      req3 = req3 & ~gnt3;
    end
    chk("lat3 busy idle", 32'(busy3), 0);
    // Reset with two reads in flight.
    step(4'h3);
    chk("rst pre gnt0", 32'(gnt), 1);
    step(4'h2);
    chk("rst pre gnt1", 32'(gnt), 2);
    chk("rst pre busy", 32'(busy), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 0);
    chk("async rst mem_ren", 32'(mem_ren), 0);
    chk("async rst mem_addr", mem_addr, 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst rdata", rdata, 0);
    step(4'h0);
    step(4'h0);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(4'h0);
      chk($sformatf("post rst rvalid c%0d", c), 32'(rvalid), 0);
      chk($sformatf("post rst rdata c%0d", c), rdata, 0);
    end
    step(4'h6);
    chk("post rst first gnt", 32'(gnt), 2);
    chk("post rst mem_addr", mem_addr, A1);
    step(4'h4);
    chk("post rst second gnt", 32'(gnt), 4);
    step(4'h0);
    step(4'h0);
    step(4'h0);
    chk("post rst drained", 32'(busy), 0);
`ifdef NODE_ARB_STATS_EN
    begin
      logic [31:0] g0, s0;
      int exp_g, exp_s;
      g0 = grant_count;
      s0 = stall_cycles;
      exp_g = 0;
      exp_s = 0;
      for (int c = 0; c < 14; c++) begin
        logic [3:0] e;
        req = (c < 10) ? 4'h3 : 4'h0;
        e = req & ~busy;
        if (e[0] && e[1]) exp_s++;
        @(posedge clk);
        #1;
        if (mem_ren) exp_g++;
      end
      chk("stats grant_count", grant_count - g0, 32'(exp_g));
      chk("stats stall_cycles", stall_cycles - s0, 32'(exp_s));
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_mem_arbiter.md
Name: node_mem_arbiter

Overview:
- Shares one single-read-port octree node memory between NUM_CORES ray processors.
- Each processor issues node reads through a req/gnt handshake; the arbiter grants at most one read per cycle using round-robin.
- Granted reads are tracked through a MEM_LATENCY-deep tag pipeline, and the response is steered back to the issuing core.
- Sits between the ray processor array and the node ROM, replacing per-core ROM ports.

Parameters:
- NUM_CORES, 4, number of requesting ray processors (2..8).
- ADDR_W, 32, node address width.
- DATA_W, 32, node word width.
- MEM_LATENCY, 1, cycles from mem_ren to valid mem_rdata (1..4).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_CORES  per-core read request
- req_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_CORES  one-cycle grant pulse per core
- rvalid  out  NUM_CORES  one-cycle response-valid per core
- rdata  out  DATA_W  response data, shared by all cores, qualified by rvalid
- mem_ren  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_ren
- busy  out  NUM_CORES  core has an outstanding read

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: gnt=0, rvalid=0, rdata=0, mem_ren=0, mem_addr=0, busy=0, rr_ptr=0, tag pipeline valid bits=0.
- Eligibility: core i is eligible when req[i]=1 and busy[i]=0.
- Arbitration:
  - Each cycle, pick the first eligible core searching from rr_ptr upward, with modulo-NUM_CORES wrap.
  - At the clock edge, register gnt[k]=1, mem_ren=1, mem_addr=req_addr[k], set busy[k]=1, and set rr_ptr=(k+1) mod NUM_CORES.
  - If no core is eligible: gnt=0, mem_ren=0, mem_addr holds its last value, rr_ptr unchanged.
- Grant latency: a request sampled at edge N produces gnt and mem_ren in cycle N+1. The best case is one grant per cycle, back-to-back to different cores.
- Requester rules:
  - Hold req and req_addr stable until gnt is seen.
  - May deassert req in the cycle gnt is high.
  - A req still high while busy is ignored, so it is never double-granted.
- Tag pipeline:
  - Shift register of {valid, core_id[clog2(NUM_CORES)]}, MEM_LATENCY stages, loaded at the grant.
  - When the last stage is valid, register rdata=mem_rdata, pulse rvalid[id]=1 and clear busy[id] in the same cycle.
  - Response appears MEM_LATENCY+1 cycles after gnt. rdata holds its value when no response is pending.
- At most one outstanding read per core; up to MEM_LATENCY+1 reads in flight in total.
- Simultaneous events:
  - A response clearing busy[i] and a new req[i] in the same cycle: core i becomes eligible at the next edge, not the same edge.
  - A grant to core j and a response to core i≠j in the same cycle are independent.
- Reset mid-operation clears in-flight tags. Stale mem_rdata is discarded and no rvalid is produced.
- A req_addr change while req is high and not yet granted is a protocol violation (the bench asserts on it).

Optional Feature:
- Macro: NODE_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cycles, 32 bits: increments every cycle in which req&~busy has two or more bits set, so that at least one eligible core is not granted.
  - grant_count, 32 bits: increments on every mem_ren.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, neither port nor counter exists, and arbitration behaviour is identical.

Test Plan:
- Single request, MEM_LATENCY=1: req[2]=1, addr=0x40 → gnt[2] one cycle later, mem_addr=0x40; rvalid[2]=1 two cycles after gnt with rdata=mem_rdata(0x40); busy[2] goes 1→0.
- All four cores request continuously after reset → grant order 0,1,2,3 on consecutive cycles, then each core re-granted only after its rvalid; no gnt to a busy core.
- Wrap: rr_ptr=3, requests from cores 1 and 3 → grant 3, then 1; rr_ptr becomes 2.
- MEM_LATENCY=3, four back-to-back grants → four rvalid pulses in grant order, each exactly 4 cycles after its gnt, with correct data per core.
- reset_n low while two reads are in flight → all outputs return to zero asynchronously; after release no rvalid is seen for the aborted reads, and the first grant goes to the lowest eligible core.
- NODE_ARB_STATS_EN defined, cores 0 and 1 requesting for 10 cycles → grant_count equals the number of mem_ren pulses; stall_cycles counts only cycles with two or more eligible cores.
